bernoulli_estimator: RTL and testbench
======================================

Name: bernoulli_estimator

Overview:
- Receive side of the Bernoulli spike-stream path: recovers the per-channel probability (threshold) that a Bernoulli generator encoded into a bit stream.
- Counts ones per channel over a fixed window of 2^WINDOW_LOG2 accepted samples, then presents a CMP_WIDTH-bit estimate per channel on a valid/ready output port.
- Used to close the loop in test columns and to monitor generated spike densities against programmed thresholds.

Parameters:
- OUTPUTS, 8, number of parallel Bernoulli channels (matches generator OUTPUTS).
- CMP_WIDTH, 7, width of each recovered estimate (matches generator threshold width).
- WINDOW_LOG2, 7, log2 of window length in accepted samples; must be >= CMP_WIDTH (elaboration error otherwise).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: clear and begin a window.
- in_valid  input  1  sample qualifier for `in`.
- in  input  OUTPUTS  one Bernoulli bit per channel.
- busy  output  1  high in ACCUM.
- est_valid  output  1  estimates valid.
- est_ready  input  1  consumer accepts estimates.
- est  output  OUTPUTS x CMP_WIDTH  packed per-channel estimates, channel i at est[i].
- dropped  output  1  sticky: a valid sample arrived in HOLD; cleared by start.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, est_valid=0, est=0, dropped=0; all counters 0.
- Counters:
  - Sample counter is WINDOW_LOG2 bits.
  - Per-channel ones counters are WINDOW_LOG2+1 bits, so an all-ones window (2^WINDOW_LOG2) does not wrap.
- IDLE:
  - start=1 clears all counters and dropped, then enters ACCUM next cycle.
  - in_valid is ignored.
- ACCUM:
  - Each cycle with in_valid=1, every channel counter adds in[i] and the sample counter increments.
  - start=1 in ACCUM restarts the window: counters cleared and the sample that cycle is discarded. start has priority over in_valid.
  - When the sample counter equals 2^WINDOW_LOG2-1 and in_valid=1, the final sample is included. The estimates are registered and the state moves to HOLD.
  - Latency: est_valid rises the cycle after the last accepted sample.
- Estimate arithmetic, per channel:
  - est = count >> (WINDOW_LOG2-CMP_WIDTH).
  - The result saturates to 2^CMP_WIDTH-1 when the shifted value reaches 2^CMP_WIDTH (all-ones window).
  - No rounding; truncate.
- HOLD:
  - est_valid=1 and est is stable until the handshake (est_valid & est_ready).
  - On handshake: est_valid falls the next cycle and the state returns to IDLE (see Optional Feature).
  - in_valid=1 sets dropped; the sample is not counted.
  - start is ignored.
- est retains its last value after the handshake; it is only updated at the end of a window.
- rst_n asserted mid-window: immediate return to reset values; partial counts lost.

Optional Feature:
- Macro BERNOULLI_EST_CONTINUOUS_EN.
- Defined:
  - On the HOLD handshake, the state goes directly to ACCUM with counters cleared.
  - A valid sample in the handshake cycle is counted as sample 0 of the new window and does not set dropped.
  - After the first start the block free-runs; start still restarts the current window in ACCUM.
- Undefined: HOLD returns to IDLE on handshake, and every window requires a start pulse.

Decomposition:
- Shared package (internal_defines or a bernoulli_pkg) holds:
  - state enum {IDLE, ACCUM, HOLD};
  - a function computing the saturating shift estimate;
  - a localparam WINDOW = 2**WINDOW_LOG2.
- One natural sub-module, bernoulli_ones_counter: per-channel WINDOW_LOG2+1-bit counter with clear/enable, instantiated OUTPUTS times by generate.
- FSM and sample counter live in the top.

Test Plan:
- Use OUTPUTS=2, CMP_WIDTH=3, WINDOW_LOG2=4 unless noted.
- Ch0 all ones, ch1 alternating 1010…, 16 valid samples after start:
  - est_valid the cycle after the 16th sample;
  - est[0]=7 (16>>1 saturated), est[1]=4.
- Ch0 all zeros, ch1 three ones, in_valid toggling 50%: exactly 16 accepted samples are counted regardless of gaps; est[0]=0, est[1]=1.
- Back-pressure: est_ready held low for 5 cycles with in_valid=1 during HOLD:
  - est stable, dropped=1;
  - the next start clears dropped and the counters.
- start at sample 9 of a window, then 16 samples of all ones: est[0]=7, and the earlier 9 samples are not included.
- rst_n low at sample 10: outputs 0 immediately (asynchronous, mid-cycle check); after release, IDLE ignores in_valid until start.
- With BERNOULLI_EST_CONTINUOUS_EN defined:
  - single start, est_ready=1, ch1 always 1: est_valid pulses every 16 accepted samples and est[1]=7 each window;
  - no sample lost at the handshake; dropped stays 0.

Source files
------------

// File: rtl/bernoulli_pkg.sv
// Shared types and estimate arithmetic for the Bernoulli stream estimator.
package bernoulli_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_OUTPUTS     = 8;
  localparam int DEF_CMP_WIDTH   = 7;
  localparam int DEF_WINDOW_LOG2 = 7;
  localparam int WINDOW          = 2**DEF_WINDOW_LOG2;

  // Truncating shift; only an all-ones window can reach 2^cmp_width, which clamps.
  function automatic logic [31:0] sat_estimate(input logic [31:0] count,
                                               input int          shift,
                                               input int          cmp_width);
    logic [31:0] shifted;
    logic [31:0] max_val;
    shifted = count >> shift;
    max_val = (32'd1 << cmp_width) - 32'd1;
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

// File: rtl/bernoulli_ones_counter.sv
// One channel's ones counter; clear wins over the old count but still adds the
// current bit, so a window can restart and take its first sample in one cycle.
module bernoulli_ones_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] count
);

  logic inc;
  assign inc = en & bit_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || inc) begin
      count <= (clr ? '0 : count) + WIDTH'(inc);
    end
  end

endmodule

// File: rtl/bernoulli_estimator.sv
// Recovers per-channel Bernoulli probability over 2^WINDOW_LOG2 accepted samples.
// est_valid rises the cycle after the last sample; est held until est_ready, samples seen in HOLD set dropped.
// BERNOULLI_EST_CONTINUOUS_EN: the handshake restarts the next window instead of returning to IDLE.
module bernoulli_estimator
  import bernoulli_pkg::*;
#(
  parameter int OUTPUTS     = DEF_OUTPUTS,
  parameter int CMP_WIDTH   = DEF_CMP_WIDTH,
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              in_valid,
  input  logic [OUTPUTS-1:0]                in,
  output logic                              busy,
  output logic                              est_valid,
  input  logic                              est_ready,
  output logic [OUTPUTS-1:0][CMP_WIDTH-1:0] est,
  output logic                              dropped
);

  if (WINDOW_LOG2 < CMP_WIDTH) begin : g_param_check
    $error("bernoulli_estimator: WINDOW_LOG2 must be >= CMP_WIDTH");
  end

  state_t                              state, state_nxt;
  logic   [WINDOW_LOG2-1:0]            samp_cnt;
  logic   [OUTPUTS-1:0][WINDOW_LOG2:0] ones_cnt;
  logic   [OUTPUTS-1:0][CMP_WIDTH-1:0] est_nxt;
  logic                                cnt_clr;
  logic                                cnt_en;
  logic                                last;
  logic                                dropped_set;
  logic                                dropped_clr;

  for (genvar i = 0; i < OUTPUTS; i++) begin : g_ch
    bernoulli_ones_counter #(
      .WIDTH (WINDOW_LOG2 + 1)
    ) u_ones_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .bit_in (in[i]),
      .count  (ones_cnt[i])
    );
  end

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    last        = 1'b0;
    dropped_set = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          cnt_clr = 1'b1;
        end else if (in_valid) begin
          cnt_en = 1'b1;
          if (samp_cnt == '1) begin
            last      = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
`ifdef BERNOULLI_EST_CONTINUOUS_EN
        if (est_ready) begin
          cnt_clr   = 1'b1;
          cnt_en    = in_valid;
          state_nxt = ACCUM;
        end else begin
          dropped_set = in_valid;
        end
`else
        dropped_set = in_valid;
        if (est_ready) begin
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dropped_clr = start && (state != HOLD);

  // The final sample is folded in here because its counter update lands on the same edge.
  always_comb begin
    est_nxt = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      est_nxt[i] = CMP_WIDTH'(sat_estimate(32'(ones_cnt[i]) + 32'(in[i]),
                                           WINDOW_LOG2 - CMP_WIDTH, CMP_WIDTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      samp_cnt <= '0;
      est      <= '0;
      dropped  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr) begin
        samp_cnt <= cnt_en ? WINDOW_LOG2'(1) : '0;
      end else if (cnt_en) begin
        samp_cnt <= samp_cnt + WINDOW_LOG2'(1);
      end
      if (last) begin
        est <= est_nxt;
      end
      if (dropped_clr) begin
        dropped <= 1'b0;
      end else if (dropped_set) begin
        dropped <= 1'b1;
      end
    end
  end

  assign busy      = (state == ACCUM);
  assign est_valid = (state == HOLD);

endmodule

// File: tb/tb_bernoulli_estimator.sv
// Randomized and directed bench for bernoulli_estimator against a window-level reference model.
module tb_bernoulli_estimator;

  localparam int OUT   = 2;
  localparam int CW    = 3;
  localparam int WL    = 4;
  localparam int WIN   = 16;
  localparam int SHIFT = 1;
  localparam int MAXE  = 7;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     est_ready = 1'b0;
  logic [OUT-1:0]           in_bits = '0;
  logic                     busy;
  logic                     est_valid;
  logic                     dropped;
  logic [OUT-1:0][CW-1:0]   est;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bernoulli_estimator #(
    .OUTPUTS     (OUT),
    .CMP_WIDTH   (CW),
    .WINDOW_LOG2 (WL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in        (in_bits),
    .busy      (busy),
    .est_valid (est_valid),
    .est_ready (est_ready),
    .est       (est),
    .dropped   (dropped)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a window is a list of accepted samples; the estimate is ones/2^SHIFT clamped.
  bit m_active, m_holding, m_dropped;
  int m_n;
  int m_ones [OUT];
  int m_est  [OUT];

  function automatic int expect_est(input int ones);
    int e;
    e = ones / (1 << SHIFT);
    if (e > MAXE) e = MAXE;
    return e;
  endfunction

  task automatic new_window();
    m_n = 0;
    for (int i = 0; i < OUT; i++) m_ones[i] = 0;
  endtask

  task automatic take_sample();
    for (int i = 0; i < OUT; i++) m_ones[i] += int'(in_bits[i]);
    m_n++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_holding = 0; m_dropped = 0;
      new_window();
      for (int i = 0; i < OUT; i++) m_est[i] = 0;
    end else if (m_holding) begin
`ifdef BERNOULLI_EST_CONTINUOUS_EN
      if (est_ready) begin
        m_holding = 0;
        m_active  = 1;
        new_window();
        if (in_valid) take_sample();
      end else if (in_valid) begin
        m_dropped = 1;
      end
`else
      if (in_valid) m_dropped = 1;
      if (est_ready) m_holding = 0;
`endif
    end else if (m_active) begin
      if (start) begin
        new_window();
        m_dropped = 0;
      end else if (in_valid) begin
        take_sample();
        if (m_n == WIN) begin
          for (int i = 0; i < OUT; i++) m_est[i] = expect_est(m_ones[i]);
          m_active  = 0;
          m_holding = 1;
        end
      end
    end else if (start) begin
      m_active = 1;
      m_dropped = 0;
      new_window();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(m_active));
      chk("est_valid", int'(est_valid), int'(m_holding));
      chk("dropped", int'(dropped), int'(m_dropped));
      for (int i = 0; i < OUT; i++) chk("est", int'(est[i]), m_est[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    est_ready = 1'b1;
    tick();
    est_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int pulses;

    // reset state
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_est_valid", int'(est_valid), 0);
    chk("rst_est", int'(est), 0);
    chk("rst_dropped", int'(dropped), 0);
    rst_n = 1'b1;
    tick();

    // ch0 all ones, ch1 alternating
    pulse_start();
    for (int k = 0; k < WIN; k++) begin
      in_valid = 1'b1;
      in_bits  = {1'(k % 2 == 0), 1'b1};
      tick();
      if (k == WIN - 2) chk("t1_not_yet_valid", int'(est_valid), 0);
    end
    chk("t1_latency_valid", int'(est_valid), 1);
    chk("t1_est0", int'(est[0]), 7);
    chk("t1_est1", int'(est[1]), 4);
    handshake();
    chk("t1_valid_falls", int'(est_valid), 0);
    chk("t1_est_retained", int'(est[0]), 7);

    // gapped input: 16 accepted samples, ch1 has three ones
    pulse_start();
    acc = 0;
    for (int c = 0; c < 4 * WIN && acc < WIN; c++) begin
      in_valid = 1'(c % 2);
      in_bits  = {1'(acc == 2 || acc == 5 || acc == 9), 1'b0};
      tick();
      if (in_valid) acc++;
    end
    in_valid = 1'b0;
    chk("t2_accepted", acc, WIN);
    chk("t2_valid", int'(est_valid), 1);
    chk("t2_est0", int'(est[0]), 0);
    chk("t2_est1", int'(est[1]), 1);
    handshake();

    // back-pressure in HOLD
    pulse_start();
    for (int k = 0; k < WIN; k++) begin
      in_valid = 1'b1;
      in_bits  = {1'b1, 1'(k < 6)};
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_bits  = 2'(k);
      tick();
      chk("t3_hold_valid", int'(est_valid), 1);
      chk("t3_hold_est0", int'(est[0]), 3);
      chk("t3_hold_est1", int'(est[1]), 7);
      chk("t3_dropped", int'(dropped), 1);
    end
    handshake();
    pulse_start();
    chk("t3_dropped_cleared", int'(dropped), 0);
    chk("t3_busy_after_start", int'(busy), 1);

    // restart at sample 9
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_bits  = 2'b10;
      tick();
    end
    in_bits  = 2'b11;
    in_valid = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      in_valid = 1'b1;
      in_bits  = 2'b01;
      tick();
    end
    chk("t4_valid", int'(est_valid), 1);
    chk("t4_est0", int'(est[0]), 7);
    chk("t4_est1", int'(est[1]), 0);
    handshake();

    // asynchronous reset mid-window
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_bits  = 2'($urandom_range(0, 3));
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_est_valid", int'(est_valid), 0);
    chk("t5_rst_est", int'(est), 0);
    chk("t5_rst_dropped", int'(dropped), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_bits  = 2'b11;
      tick();
      chk("t5_idle_ignores", int'(busy), 0);
    end
    pulse_start();
    for (int k = 0; k < WIN; k++) begin
      in_valid = 1'b1;
      in_bits  = 2'b10;
      tick();
    end
    chk("t5_est0", int'(est[0]), 0);
    chk("t5_est1", int'(est[1]), 7);
    handshake();

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      start     = 1'($urandom_range(0, 99) < 3);
      in_valid  = 1'($urandom_range(0, 3) != 0);
      est_ready = 1'($urandom_range(0, 1));
      in_bits   = 2'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0;
    handshake();

`ifdef BERNOULLI_EST_CONTINUOUS_EN
    // free-running windows after a single start
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulse_start();
    pulses    = 0;
    est_ready = 1'b1;
    for (int t = 1; t <= 5 * WIN; t++) begin
      in_valid = 1'b1;
      in_bits  = {1'b1, 1'($urandom_range(0, 1))};
      tick();
      if (est_valid) begin
        pulses++;
        chk("cont_est1", int'(est[1]), 7);
      end
      chk("cont_dropped", int'(dropped), 0);
    end
    chk("cont_pulses", pulses, 5);
    est_ready = 1'b0;
    in_valid  = 1'b0;
`else
    pulses = 0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
